conv_frame_ctrl: RTL and testbench

- Frame-level sequencer for the greyscale -> 3x3 convolution -> abs pixel datapath.
- Arms on a frame request and latches the kernel mode for the whole frame.
- Counts incoming greyscale pixels in raster order, gates the convolution start/valid strobe and flags which pixels complete an interior 3x3 window.
- Delays window coordinates through a PIPE_LAT-deep shadow pipe so they line up with the abs output, and signals end of frame after the pipe drains.

---
 rtl/conv_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for the greyscale -> 3x3 convolution -> abs datapath.
// Counts raster pixels, gates the convolution strobe, flags interior windows
// and delays window centres so they line up with the abs result.
module conv_frame_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_req,
    input  logic [1:0]       mode_in,
    input  logic             pix_valid_in,
    input  logic             err_clr,
    output logic             conv_start,
    output logic [1:0]       kernel_sel,
    output logic             win_valid,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_x,
    output logic [CNT_W-1:0] out_y,
    output logic             busy,
    output logic             frame_done,
    output logic             err_sticky
);

    localparam int DC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  x_q, y_q;
    logic [DC_W-1:0]   dcnt_q;
    logic              last_col, last_row, last_pix, accept_req, err_set;

    logic              pv_q [PIPE_LAT];
    logic [CNT_W-1:0]  px_q [PIPE_LAT];
    logic [CNT_W-1:0]  py_q [PIPE_LAT];

    assign accept_req = (state_q == S_IDLE) & frame_start_req;
    assign conv_start = (state_q == S_RUN) & pix_valid_in;
    assign last_col   = (x_q == CNT_W'(IMG_W - 1));
    assign last_row   = (y_q == CNT_W'(IMG_H - 1));
    assign last_pix   = conv_start & last_col & last_row;
    assign win_valid  = conv_start & (x_q >= CNT_W'(2)) & (y_q >= CNT_W'(2));
    assign busy       = (state_q == S_RUN) | (state_q == S_DRAIN);
    assign frame_done = (state_q == S_DONE);

    assign out_valid  = pv_q[PIPE_LAT-1];
    assign out_x      = px_q[PIPE_LAT-1];
    assign out_y      = py_q[PIPE_LAT-1];

    // Protocol violations: pixels outside RUN, requests while a frame is active
    assign err_set = (pix_valid_in & (state_q != S_RUN))
                   | (frame_start_req & busy);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start_req) state_d = S_RUN;
            S_RUN:   if (last_pix) state_d = S_DRAIN;
            S_DRAIN: if (dcnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raster x/y counters, advanced by each accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept_req) begin
            x_q <= '0;
            y_q <= '0;
        end else if (conv_start) begin
            if (last_col) begin
                x_q <= '0;
                y_q <= last_row ? '0 : y_q + CNT_W'(1);
            end else begin
                x_q <= x_q + CNT_W'(1);
            end
        end
    end

    // Kernel mode latched once per frame; mode 3 folds onto identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          kernel_sel <= '0;
        else if (accept_req) kernel_sel <= (mode_in == 2'd3) ? 2'd2 : mode_in;
    end

    // Drain down-counter covering the shadow pipe latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dcnt_q <= '0;
        else if (last_pix)
            dcnt_q <= DC_W'(PIPE_LAT - 1);
        else if ((state_q == S_DRAIN) && (dcnt_q != '0))
            dcnt_q <= dcnt_q - DC_W'(1);
    end

    // Shadow pipe: valid shifts every cycle, coordinates follow only valid
    // entries so the output coordinates hold between windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= win_valid;
            if (win_valid) begin
                px_q[0] <= x_q - CNT_W'(1);
                py_q[0] <= y_q - CNT_W'(1);
            end
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) begin
                    px_q[i] <= px_q[i-1];
                    py_q[i] <= py_q[i-1];
                end
            end
        end
    end

    // Sticky protocol error; a new violation wins over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_sticky <= 1'b0;
        else if (err_set) err_sticky <= 1'b1;
        else if (err_clr) err_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on a 4x4 frame with a 3-cycle pipe.
module tb_conv_frame_ctrl;

    localparam int IMG_W    = 4;
    localparam int IMG_H    = 4;
    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start_req = 1'b0;
    logic [1:0]       mode_in = '0;
    logic             pix_valid_in = 1'b0;
    logic             err_clr = 1'b0;
    logic             conv_start;
    logic [1:0]       kernel_sel;
    logic             win_valid;
    logic             out_valid;
    logic [CNT_W-1:0] out_x;
    logic [CNT_W-1:0] out_y;
    logic             busy;
    logic             frame_done;
    logic             err_sticky;

    conv_frame_ctrl #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PIPE_LAT(PIPE_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start_req(frame_start_req),
        .mode_in        (mode_in),
        .pix_valid_in   (pix_valid_in),
        .err_clr        (err_clr),
        .conv_start     (conv_start),
        .kernel_sel     (kernel_sel),
        .win_valid      (win_valid),
        .out_valid      (out_valid),
        .out_x          (out_x),
        .out_y          (out_y),
        .busy           (busy),
        .frame_done     (frame_done),
        .err_sticky     (err_sticky)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Event log filled on the falling edge
    int          cyc = 0;
    int          n_conv = 0;
    int          ks_bad = 0;
    logic [1:0]  exp_ks = '0;
    int          win_q [$];
    int          out_cyc_q [$];
    int          out_x_q [$];
    int          out_y_q [$];
    int          done_q [$];

    // Expected window centres of a 4x4 frame, in raster order
    int exp_x [4] = '{1, 2, 1, 2};
    int exp_y [4] = '{1, 1, 2, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle counter on the active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT outputs away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (conv_start) n_conv++;
            if (win_valid) win_q.push_back(cyc);
            if (out_valid) begin
                out_cyc_q.push_back(cyc);
                out_x_q.push_back(int'(out_x));
                out_y_q.push_back(int'(out_y));
            end
            if (frame_done) done_q.push_back(cyc);
            if (busy && kernel_sel != exp_ks) ks_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_conv = 0;
        ks_bad = 0;
        win_q.delete();
        out_cyc_q.delete();
        out_x_q.delete();
        out_y_q.delete();
        done_q.delete();
    endtask

    // Runs one 4x4 frame starting from an IDLE cycle; returns in the IDLE
    // cycle right after frame_done
    task automatic run_frame(input string name, input logic [1:0] mode,
                             input logic [1:0] ks, input bit gap, input bit req_mid);
        bit seen;
        clear_log();
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_done"}, frame_done, 0);
        frame_start_req = 1'b1;
        mode_in = mode;
        exp_ks = ks;
        tick();
        frame_start_req = 1'b0;
        mode_in = 2'd0;
        for (int p = 0; p < IMG_W * IMG_H; p++) begin
            pix_valid_in = 1'b1;
            frame_start_req = req_mid && (p == 5);
            tick();
            pix_valid_in = 1'b0;
            frame_start_req = 1'b0;
            if (gap) tick();
        end
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (done_q.size() != 0) seen = 1;
        end
        check({name, "_done_seen"}, done_q.size(), 1);
        tick();
        check({name, "_conv_cnt"}, n_conv, IMG_W * IMG_H);
        check({name, "_out_cnt"}, out_cyc_q.size(), 4);
        check({name, "_kernel_sel"}, ks_bad, 0);
        for (int i = 0; i < 4; i++) begin
            if (out_cyc_q.size() > i && win_q.size() > i) begin
                check({name, "_out_x"}, out_x_q[i], exp_x[i]);
                check({name, "_out_y"}, out_y_q[i], exp_y[i]);
                check({name, "_lat"}, out_cyc_q[i] - win_q[i], PIPE_LAT);
            end
        end
        if (out_cyc_q.size() == 4 && seen)
            check({name, "_done_cyc"}, done_q[0] - out_cyc_q[3], 1);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_done_pulse"}, frame_done, 0);
    endtask

    initial begin
        #2;
        // Reset state
        check("rst_conv", conv_start, 0);
        check("rst_ks", kernel_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_outv", out_valid, 0);
        check("rst_outx", out_x, 0);
        check("rst_err", err_sticky, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_frame("f_b2b", 2'd1, 2'd1, 0, 0);
        run_frame("f_gap", 2'd1, 2'd1, 1, 0);
        check("err_clean", err_sticky, 0);
        tick();
        run_frame("f_mode3", 2'd3, 2'd2, 0, 0);
        check("ks_hold", kernel_sel, 2);

        // Pixel in IDLE: dropped, flags error
        pix_valid_in = 1'b1;
        #3;
        check("idle_conv", conv_start, 0);
        tick();
        pix_valid_in = 1'b0;
        check("err_idle_pix", err_sticky, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", err_sticky, 0);

        // Request during RUN: ignored, error set, frame still completes
        run_frame("f_req_run", 2'd0, 2'd0, 0, 1);
        check("err_req_run", err_sticky, 1);
        check("err_new_frame_keeps", err_sticky, 1);
        err_clr = 1'b1;
        pix_valid_in = 1'b1;
        tick();
        err_clr = 1'b0;
        pix_valid_in = 1'b0;
        check("err_set_wins", err_sticky, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr2", err_sticky, 0);

        // Asynchronous reset mid-frame
        frame_start_req = 1'b1;
        mode_in = 2'd1;
        tick();
        frame_start_req = 1'b0;
        for (int p = 0; p < 7; p++) begin
            pix_valid_in = 1'b1;
            tick();
        end
        check("pre_rst_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_conv", conv_start, 0);
        check("arst_busy", busy, 0);
        check("arst_ks", kernel_sel, 0);
        check("arst_outv", out_valid, 0);
        check("arst_win", win_valid, 0);
        pix_valid_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
        repeat (6) tick();
        check("post_rst_outv", out_cyc_q.size(), 0);
        check("post_rst_conv", n_conv, 0);
        check("post_rst_err", err_sticky, 0);
        run_frame("f_after_rst", 2'd0, 2'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
